// File: rtl/clk_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_sched_pkg
// Description : Shared encodings for the clock-enable scheduler: FSM states
//               and command op codes (also used by the MMIO decoder).
// Revision    : 1.0 - initial release
// ============================================================================
package clk_sched_pkg;

    typedef enum logic [1:0] {
        RST_SEQ = 2'd0,
        HALT    = 2'd1,
        RUN     = 2'd2,
        STEP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_RUN    = 2'd0;
    localparam logic [1:0] OP_HALT   = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SETDIV = 2'd3;

endpackage : clk_sched_pkg
`default_nettype wire

// File: rtl/ce_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : ce_prescaler
// Description : Programmable prescaler. Counts 0..div while enabled and
//               flags tick when the count equals div (period div+1).
// Revision    : 1.0 - initial release
// ============================================================================
module ce_prescaler #(
    parameter int ARG_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ARG_W-1:0] div,
    input  logic             clear,
    input  logic             enable,
    output logic             tick
);

    logic [ARG_W-1:0] pre;

    assign tick = (pre == div);

    // Count while enabled and wrap on tick; a clear restarts the period at 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre <= '0;
        end else if (clear) begin
            pre <= '0;
        end else if (enable) begin
            if (tick) begin
                pre <= '0;
            end else begin
                pre <= pre + ARG_W'(1);
            end
        end
    end

endmodule : ce_prescaler
`default_nettype wire

// File: rtl/clk_sched.sv
`default_nettype none
// ============================================================================
// Module      : clk_sched
// Description : Staged reset sequencer plus clock-enable scheduler with
//               HALT / RUN / STEP-N / divided-rate modes, commanded over a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sched
    import clk_sched_pkg::*;
#(
    parameter int NSTAGE    = 3,
    parameter int STAGE_GAP = 4,
    parameter int ARG_W     = 16,
    parameter int BOOT_RUN  = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ARG_W-1:0]  cmd_arg,
    output logic              ce,
    output logic [NSTAGE-1:0] stage_resetn,
    output logic [1:0]        state,
    output logic              done
);

    localparam int SEQ_END = NSTAGE * STAGE_GAP;
    localparam int SEQ_W   = $clog2(SEQ_END + 1);

    state_t            cur_state;
    logic [SEQ_W-1:0]  seq;
    logic [SEQ_W-1:0]  seq_next;
    logic [ARG_W-1:0]  div;
    logic [ARG_W-1:0]  rem;
    logic [NSTAGE-1:0] stage_hit;
    logic              accept;
    logic              active;
    logic              tick;

    assign state     = cur_state;
    assign cmd_ready = (cur_state != RST_SEQ);
    assign accept    = cmd_valid & cmd_ready;

    // Prescaler only advances while enables are actually being produced
    assign active    = (cur_state == RUN) | ((cur_state == STEP) & (rem != '0));
    assign ce        = tick & active;

    // Stage thresholds are compared against the post-edge count so that a
    // stage output rises on the same edge that seq reaches its threshold
    assign seq_next  = seq + SEQ_W'(1);

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        assign stage_hit[i] = (seq_next >= SEQ_W'((i + 1) * STAGE_GAP));
    end

    ce_prescaler #(
        .ARG_W (ARG_W)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .div    (div),
        .clear  (accept),
        .enable (active),
        .tick   (tick)
    );

    // Main FSM: reset sequencing, command handling and step countdown
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state    <= RST_SEQ;
            seq          <= '0;
            div          <= '0;
            rem          <= '0;
            done         <= 1'b0;
            stage_resetn <= '0;
        end else begin
            done <= 1'b0;
            if (cur_state == RST_SEQ) begin
                seq          <= seq_next;
                stage_resetn <= stage_resetn | stage_hit;
                if (seq_next == SEQ_W'(SEQ_END)) begin
                    cur_state <= (BOOT_RUN != 0) ? RUN : HALT;
                end
            end else if (accept) begin
                // A command wins over step exhaustion in the same cycle
                case (cmd_op)
                    OP_RUN: begin
                        cur_state <= RUN;
                    end
                    OP_HALT: begin
                        cur_state <= HALT;
                        rem       <= '0;
                    end
                    OP_STEP: begin
                        if (cmd_arg == '0) begin
                            cur_state <= HALT;
                            done      <= 1'b1;
                        end else begin
                            cur_state <= STEP;
                            rem       <= cmd_arg;
                        end
                    end
                    default: begin
                        div <= cmd_arg;
                    end
                endcase
            end else if ((cur_state == STEP) && ce) begin
                rem <= rem - ARG_W'(1);
                if (rem == ARG_W'(1)) begin
                    cur_state <= HALT;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule : clk_sched
`default_nettype wire

// File: tb/tb_clk_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_sched
// Description : Directed self-checking bench for clk_sched (defaults:
//               NSTAGE=3, STAGE_GAP=4, ARG_W=16, BOOT_RUN=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_sched;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        ce;
    logic [2:0]  stage_resetn;
    logic [1:0]  state;
    logic        done;

    int n_checks;
    int n_fail;

    clk_sched #(
        .NSTAGE    (3),
        .STAGE_GAP (4),
        .ARG_W     (16),
        .BOOT_RUN  (0)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .ce           (ce),
        .stage_resetn (stage_resetn),
        .state        (state),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command; it is accepted at the next rising edge
    task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 16'd0;
    endtask

    // Expects resetn to have just been released away from a rising edge
    task automatic check_seq(input string tag);
        logic [2:0] exp_stage;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp_stage = (e >= 12) ? 3'b111 : (e >= 8) ? 3'b011 : (e >= 4) ? 3'b001 : 3'b000;
            chk({tag, "_stage"}, stage_resetn, exp_stage);
            chk({tag, "_state"}, state, (e >= 12) ? 1 : 0);
            chk({tag, "_ready"}, cmd_ready, (e >= 12) ? 1 : 0);
            chk({tag, "_ce"}, ce, 0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 16'd0;

        // Reset state
        #2;
        chk("rst_state", state, 0);
        chk("rst_stage", stage_resetn, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_ce", ce, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check_seq("seq1");

        // RUN at div=0: ce every cycle
        send_cmd(2'd0, 16'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("run_ce", ce, 1);
            chk("run_state", state, 2);
        end
        // SET_DIV 3 mid-run: ce in cycles j+4, j+8
        send_cmd(2'd3, 16'd3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("div3_ce", ce, (c % 4 == 0) ? 1 : 0);
            chk("div3_state", state, 2);
        end
        send_cmd(2'd1, 16'd0);
        @(negedge clk);
        chk("halt_state", state, 1);
        chk("halt_ce", ce, 0);
        chk("halt_done", done, 0);
        send_cmd(2'd3, 16'd0);

        // STEP 5 at div=0
        send_cmd(2'd2, 16'd5);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("step5_ce", ce, (c <= 5) ? 1 : 0);
            chk("step5_done", done, (c == 6) ? 1 : 0);
            chk("step5_state", state, (c <= 5) ? 3 : 1);
        end

        // STEP 0: immediate done, no ce
        send_cmd(2'd2, 16'd0);
        @(negedge clk);
        chk("step0_ce", ce, 0);
        chk("step0_done", done, 1);
        chk("step0_state", state, 1);
        @(negedge clk);
        chk("step0_done_clr", done, 0);

        // STEP 3 at div=2 with HALT in the final ce cycle
        send_cmd(2'd3, 16'd2);
        send_cmd(2'd2, 16'd3);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("step3_ce", ce, (c % 3 == 0) ? 1 : 0);
            chk("step3_state", state, 3);
            chk("step3_done", done, 0);
        end
        @(negedge clk);
        chk("step3_last_ce", ce, 1);
        send_cmd(2'd1, 16'd0);
        @(negedge clk);
        chk("coll_state", state, 1);
        chk("coll_done", done, 0);
        chk("coll_ce", ce, 0);
        @(negedge clk);
        chk("coll_done2", done, 0);

        // Reset mid-STEP with rem=7 (div still 2)
        send_cmd(2'd2, 16'd7);
        @(negedge clk);
        chk("pre_rst_state", state, 3);
        resetn = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_stage", stage_resetn, 0);
        chk("arst_ce", ce, 0);
        chk("arst_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check_seq("seq2");

        // div back to 0: RUN gives ce every cycle
        send_cmd(2'd0, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("rerun_ce", ce, 1);
            chk("rerun_state", state, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clk_sched
`default_nettype wire
